// File: rtl/sub_counter.sv
// Enabled-cycle counter with sticky completion flag, completion pulse and wrap pulse.
// Optional macro SUB_SIM_FINISH_EN: announce completion and end the simulation when done sets.
module sub_counter #(
    parameter int          CNT_W        = 32,
    parameter int unsigned FINISH_COUNT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             at_finish,
    output logic             done,
    output logic             done_pulse,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] FINISH_C = CNT_W'(FINISH_COUNT);

    logic [CNT_W-1:0] r_count;
    logic             r_done;
    logic             r_done_pulse;
    logic             r_wrap;

    logic w_inc;
    logic w_at_finish;
    logic w_all_ones;

    // Counting stops once done is set; only clr or reset restart it.
    assign w_inc       = en && !r_done;
    assign w_at_finish = (r_count >= FINISH_C);
    assign w_all_ones  = &r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count      <= '0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_wrap       <= 1'b0;
        end else if (clr) begin
            r_count      <= '0;
            r_done       <= 1'b0;
            r_done_pulse <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_done_pulse <= 1'b0;
            r_wrap       <= 1'b0;
            if (w_inc) begin
                r_count <= r_count + CNT_W'(1);
                if (w_at_finish) begin
                    r_done       <= 1'b1;
                    r_done_pulse <= 1'b1;
                end
                if (w_all_ones) begin
                    r_wrap <= 1'b1;
                end
            end
        end
    end

`ifdef SUB_SIM_FINISH_EN
    always @(posedge clk) begin
        if (!reset && !clr && w_inc && w_at_finish) begin
            $display("[%0t] count_c=%0d", $time, r_count);
            $display("*-* All Finished *-*");
            $finish;
        end
    end
`else
`endif

    assign count      = r_count;
    assign at_finish  = w_at_finish;
    assign done       = r_done;
    assign done_pulse = r_done_pulse;
    assign wrap       = r_wrap;

endmodule

// File: tb/tb_sub_counter.sv
// Scoreboard bench for sub_counter: a default instance and a CNT_W=4/FINISH_COUNT=15 instance share stimulus.
module tb_sub_counter;

    typedef struct {
        longint unsigned cnt;
        bit              dn;
        bit              pls;
        bit              wrp;
    } st_t;

    typedef struct {
        st_t a;
        st_t b;
    } pair_t;

    localparam int              W_A = 32;
    localparam longint unsigned F_A = 3;
    localparam int              W_B = 4;
    localparam longint unsigned F_B = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;

    logic [31:0] count_a;
    logic        at_finish_a, done_a, done_pulse_a, wrap_a;
    logic [3:0]  count_b;
    logic        at_finish_b, done_b, done_pulse_b, wrap_b;

    int n_tests = 0;
    int n_fail  = 0;

    pair_t q[$];
    st_t   m_a, m_b;

    always #5 clk = ~clk;

    sub_counter #(.CNT_W(W_A), .FINISH_COUNT(3)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clr        (clr),
        .count      (count_a),
        .at_finish  (at_finish_a),
        .done       (done_a),
        .done_pulse (done_pulse_a),
        .wrap       (wrap_a)
    );

    sub_counter #(.CNT_W(W_B), .FINISH_COUNT(15)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clr        (clr),
        .count      (count_b),
        .at_finish  (at_finish_b),
        .done       (done_b),
        .done_pulse (done_pulse_b),
        .wrap       (wrap_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: next state from the behavioural rules, counting modulo 2^w.
    function automatic st_t step(input st_t s, input bit e, input bit c, input int w,
                                 input longint unsigned f);
        st_t n;
        longint unsigned modv;
        modv  = 64'd1 << w;
        n     = s;
        n.pls = 1'b0;
        n.wrp = 1'b0;
        if (c) begin
            n.cnt = 0;
            n.dn  = 1'b0;
        end else if (e && !s.dn) begin
            n.cnt = (s.cnt + 1) % modv;
            if (s.cnt >= f) begin
                n.dn  = 1'b1;
                n.pls = 1'b1;
            end
            if (s.cnt + 1 == modv) n.wrp = 1'b1;
        end
        return n;
    endfunction

    function automatic st_t zero_st();
        st_t z;
        z.cnt = 0;
        z.dn  = 1'b0;
        z.pls = 1'b0;
        z.wrp = 1'b0;
        return z;
    endfunction

    task automatic cycle(input bit e, input bit c);
        pair_t p;
        en  = e;
        clr = c;
        m_a = step(m_a, e, c, W_A, F_A);
        m_b = step(m_b, e, c, W_B, F_B);
        p.a = m_a;
        p.b = m_b;
        q.push_back(p);
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count_a"}, 64'(count_a), 64'd0);
        check({tag, "_done_a"}, 64'(done_a), 64'd0);
        check({tag, "_pulse_a"}, 64'(done_pulse_a), 64'd0);
        check({tag, "_wrap_a"}, 64'(wrap_a), 64'd0);
        check({tag, "_atfin_a"}, 64'(at_finish_a), 64'd0);
        check({tag, "_count_b"}, 64'(count_b), 64'd0);
        check({tag, "_done_b"}, 64'(done_b), 64'd0);
        check({tag, "_atfin_b"}, 64'(at_finish_b), 64'd0);
    endtask

    // Monitor: each edge, compare DUT state with the prediction queued for that edge.
    initial begin
        pair_t p;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                p = q.pop_front();
                check("count_a", 64'(count_a), 64'(p.a.cnt));
                check("done_a", 64'(done_a), 64'(p.a.dn));
                check("pulse_a", 64'(done_pulse_a), 64'(p.a.pls));
                check("wrap_a", 64'(wrap_a), 64'(p.a.wrp));
                check("atfin_a", 64'(at_finish_a), 64'(p.a.cnt >= F_A));
                check("count_b", 64'(count_b), 64'(p.b.cnt));
                check("done_b", 64'(done_b), 64'(p.b.dn));
                check("pulse_b", 64'(done_pulse_b), 64'(p.b.pls));
                check("wrap_b", 64'(wrap_b), 64'(p.b.wrp));
                check("atfin_b", 64'(at_finish_b), 64'(p.b.cnt >= F_B));
            end
        end
    end

    initial begin
        int waited;
        m_a = zero_st();
        m_b = zero_st();

        #12;
        check_all_zero("reset");
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Count to done and hold.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);

        // Enable toggling.
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);

        // Clear with enable held at count 2, then resume.
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);

        // Narrow instance: 15 edges to all-ones, edge 16 wraps and completes, edge 17 holds.
        cycle(1'b0, 1'b1);
        for (int i = 0; i < 17; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // Asynchronous reset mid-cycle at count 3.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
        check("pre_reset_count_a", 64'(count_a), 64'd3);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        q.delete();
        m_a = zero_st();
        m_b = zero_st();
        @(posedge clk);
        #2;
        reset = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 24) == 0));
        end
        en  = 1'b0;
        clr = 1'b0;

        waited = 0;
        while (q.size() > 0 && waited < 5) begin
            @(posedge clk);
            #2;
            waited++;
        end
        check("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
